// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multicycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALTED).
// Define CTRL_INSTR_COUNT_EN to build the retired-instruction counter behind instr_count.
module unidade_controle_multiciclo #(
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               RW,
  output logic               MW,
  output logic               RDst,
  output logic               ASrc,
  output logic               MTG,
  output logic               PCSrc,
  output logic               Jmp,
  output logic               Jr,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               pc_en,
  output logic               halt,
  output logic               illegal,
  output logic [2:0]         state,
  output logic [31:0]        instr_count
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALTED = 3'd5} state_t;
  state_t cur, nxt;
  logic [5:0] opLat, fnLat, op, fn;
  logic [2:0] rOp;
  logic rAlu, isR, isJr, isAddi, isLw, isSw, isBeq, isJ, legal, retireExec, aSrc, inInstr;
  logic [ALUOP_W-1:0] aluOp;
  logic unusedZero;
  // beq always selects the branch path; the datapath qualifies it with zero
  assign unusedZero = zero;
  // outputs are registered from next state, so decode the live fields while still in DECODE
  assign op = (cur == DECODE) ? opcode : opLat;
  assign fn = (cur == DECODE) ? funct : fnLat;
  assign isR = op == 6'h00;
  assign isJr = isR && fn == 6'h08;
  assign isAddi = op == 6'h08;
  assign isLw = op == 6'h23;
  assign isSw = op == 6'h2B;
  assign isBeq = op == 6'h04;
  assign isJ = op == 6'h02;
  assign legal = (isR && (rAlu || isJr)) || isAddi || isLw || isSw || isBeq || isJ;
  assign retireExec = !((isR && rAlu) || isAddi || isLw || isSw);
  assign aSrc = isAddi || isLw || isSw;
  assign aluOp = ALUOP_W'((isR && rAlu) ? rOp : isBeq ? 3'd1 : 3'd0);
  assign inInstr = nxt == EXEC || nxt == MEM || nxt == WB;
  assign state = cur;
  always_comb begin
    rOp = 3'd0;
    rAlu = 1'b1;
    case (fn)
      6'h20: rOp = 3'd0;
      6'h22: rOp = 3'd1;
      6'h24: rOp = 3'd2;
      6'h25: rOp = 3'd3;
      6'h2A: rOp = 3'd4;
      6'h00: rOp = 3'd5;
      6'h02: rOp = 3'd6;
      default: rAlu = 1'b0;
    endcase
  end
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH: nxt = DECODE;
      DECODE: nxt = (op == HALT_OPCODE) ? HALTED : EXEC;
      EXEC: nxt = ((isR && rAlu) || isAddi) ? WB : (isLw || isSw) ? MEM : FETCH;
      MEM: nxt = isLw ? WB : FETCH;
      WB: nxt = FETCH;
      HALTED: nxt = HALTED;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= FETCH;
      opLat <= '0;
      fnLat <= '0;
      RW <= 1'b0;
      MW <= 1'b0;
      RDst <= 1'b0;
      ASrc <= 1'b0;
      MTG <= 1'b0;
      PCSrc <= 1'b0;
      Jmp <= 1'b0;
      Jr <= 1'b0;
      ALUop <= '0;
      pc_en <= 1'b0;
      halt <= 1'b0;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      opLat <= op;
      fnLat <= fn;
      RW <= nxt == WB;
      MW <= nxt == MEM && isSw;
      RDst <= nxt == WB && isR;
      ASrc <= inInstr && aSrc;
      MTG <= nxt == WB && isLw;
      PCSrc <= nxt == EXEC && isBeq;
      Jmp <= nxt == EXEC && isJ;
      Jr <= nxt == EXEC && isJr;
      ALUop <= inInstr ? aluOp : '0;
      pc_en <= nxt == WB || (nxt == MEM && isSw) || (nxt == EXEC && retireExec);
      halt <= nxt == HALTED;
      illegal <= illegal || (nxt == EXEC && !legal);
    end
  end
`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (pc_en) cnt <= cnt + 32'd1;
  end
  assign instr_count = cnt;
`else
  assign instr_count = '0;
`endif
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo: directed per-cycle checks of the multicycle control sequencer.
module tb_unidade_controle_multiciclo;
  logic clk, reset, zero;
  logic [5:0] opcode, funct;
  logic RW, MW, RDst, ASrc, MTG, PCSrc, Jmp, Jr, pc_en, halt, illegal;
  logic [4:0] ALUop;
  logic [2:0] state;
  logic [31:0] instr_count;
  int total = 0;
  int bad = 0;
  logic [17:0] trace [0:7];

  unidade_controle_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .RW(RW), .MW(MW), .RDst(RDst), .ASrc(ASrc), .MTG(MTG), .PCSrc(PCSrc),
    .Jmp(Jmp), .Jr(Jr), .ALUop(ALUop), .pc_en(pc_en), .halt(halt),
    .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {state, RW, MW, RDst, ASrc, MTG, PCSrc, Jmp, Jr, ALUop, pc_en, halt}
  function automatic logic [17:0] snap();
    return {state, RW, MW, RDst, ASrc, MTG, PCSrc, Jmp, Jr, ALUop, pc_en, halt};
  endfunction

  function automatic logic [17:0] ex(input logic [2:0] s, input logic [7:0] strb, input logic [4:0] alu,
                                     input logic pe, input logic h);
    return {s, strb, alu, pe, h};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run(input logic [5:0] o, input logic [5:0] f, input int n);
    opcode = o;
    funct = f;
    for (int i = 0; i < n; i++) begin
      tick();
      trace[i] = snap();
    end
  endtask

  task automatic test_reset;
    logic [17:0] fz;
    fz = ex(3'd0, 8'b0, 5'd0, 1'b0, 1'b0);
    opcode = 6'h00;
    funct = 6'h20;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    total++;
    if (snap() !== fz) begin bad++; $display("FAIL reset_held got=%h exp=%h", snap(), fz); end
    #1;
    reset = 1'b1;
    total++;
    if (snap() !== fz || illegal !== 1'b0 || instr_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_release got=%h ill=%b cnt=%0d exp=%h ill=0 cnt=0", snap(), illegal, instr_count, fz);
    end
    tick();
    total++;
    if (state !== 3'd1) begin bad++; $display("FAIL reset_first_edge state=%0d exp=1", state); end
    repeat (3) tick();
    total++;
    if (state !== 3'd0) begin bad++; $display("FAIL reset_first_instr state=%0d exp=0", state); end
  endtask

  task automatic test_rtype;
    logic [17:0] e [0:3];
    logic [5:0] fns [0:2];
    logic [4:0] alus [0:2];
    fns[0] = 6'h20; alus[0] = 5'd0;
    fns[1] = 6'h02; alus[1] = 5'd6;
    fns[2] = 6'h2A; alus[2] = 5'd4;
    for (int k = 0; k < 3; k++) begin
      e[0] = ex(3'd1, 8'b0, 5'd0, 1'b0, 1'b0);
      e[1] = ex(3'd2, 8'b0, alus[k], 1'b0, 1'b0);
      e[2] = ex(3'd4, 8'b1010_0000, alus[k], 1'b1, 1'b0);
      e[3] = ex(3'd0, 8'b0, 5'd0, 1'b0, 1'b0);
      run(6'h00, fns[k], 4);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (trace[i] !== e[i]) begin bad++; $display("FAIL rtype_f%h cyc%0d got=%h exp=%h", fns[k], i, trace[i], e[i]); end
      end
    end
  endtask

  task automatic test_mem;
    logic [17:0] e [0:4];
    e[0] = ex(3'd1, 8'b0, 5'd0, 1'b0, 1'b0);
    e[1] = ex(3'd2, 8'b0001_0000, 5'd0, 1'b0, 1'b0);
    e[2] = ex(3'd3, 8'b0001_0000, 5'd0, 1'b0, 1'b0);
    e[3] = ex(3'd4, 8'b1001_1000, 5'd0, 1'b1, 1'b0);
    e[4] = ex(3'd0, 8'b0, 5'd0, 1'b0, 1'b0);
    run(6'h23, 6'h00, 5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (trace[i] !== e[i]) begin bad++; $display("FAIL lw cyc%0d got=%h exp=%h", i, trace[i], e[i]); end
    end
    e[2] = ex(3'd3, 8'b0101_0000, 5'd0, 1'b1, 1'b0);
    e[3] = ex(3'd0, 8'b0, 5'd0, 1'b0, 1'b0);
    run(6'h2B, 6'h00, 4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (trace[i] !== e[i]) begin bad++; $display("FAIL sw cyc%0d got=%h exp=%h", i, trace[i], e[i]); end
    end
  endtask

  task automatic test_branch_jump;
    logic [5:0] ops [0:3];
    logic [5:0] fns [0:3];
    logic [17:0] ee [0:3];
    logic [17:0] d, f;
    d = ex(3'd1, 8'b0, 5'd0, 1'b0, 1'b0);
    f = ex(3'd0, 8'b0, 5'd0, 1'b0, 1'b0);
    ops[0] = 6'h04; fns[0] = 6'h00; ee[0] = ex(3'd2, 8'b0000_0100, 5'd1, 1'b1, 1'b0);
    ops[1] = 6'h04; fns[1] = 6'h00; ee[1] = ex(3'd2, 8'b0000_0100, 5'd1, 1'b1, 1'b0);
    ops[2] = 6'h00; fns[2] = 6'h08; ee[2] = ex(3'd2, 8'b0000_0001, 5'd0, 1'b1, 1'b0);
    ops[3] = 6'h02; fns[3] = 6'h00; ee[3] = ex(3'd2, 8'b0000_0010, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      zero = (k == 0);
      run(ops[k], fns[k], 3);
      total++;
      if (trace[0] !== d || trace[1] !== ee[k] || trace[2] !== f) begin
        bad++;
        $display("FAIL branch_jump op%h/f%h got=%h,%h,%h exp=%h,%h,%h", ops[k], fns[k],
                 trace[0], trace[1], trace[2], d, ee[k], f);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal;
    logic [17:0] e1;
    e1 = ex(3'd2, 8'b0, 5'd0, 1'b1, 1'b0);
    total++;
    if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b exp=0", illegal); end
    run(6'h11, 6'h00, 3);
    total++;
    if (trace[1] !== e1 || trace[2] !== ex(3'd0, 8'b0, 5'd0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL illegal_op_nop got=%h,%h exp=%h", trace[1], trace[2], e1);
    end
    total++;
    if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_set got=%b exp=1", illegal); end
    run(6'h00, 6'h20, 4);
    total++;
    if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b exp=1", illegal); end
    run(6'h00, 6'h03, 3);
    total++;
    if (trace[1] !== e1) begin bad++; $display("FAIL illegal_funct got=%h exp=%h", trace[1], e1); end
  endtask

  task automatic test_halt;
    run(6'h3F, 6'h00, 2);
    total++;
    if (trace[0] !== ex(3'd1, 8'b0, 5'd0, 1'b0, 1'b0) || trace[1] !== ex(3'd5, 8'b0, 5'd0, 1'b0, 1'b1)) begin
      bad++;
      $display("FAIL halt_enter got=%h,%h exp=%h,%h", trace[0], trace[1],
               ex(3'd1, 8'b0, 5'd0, 1'b0, 1'b0), ex(3'd5, 8'b0, 5'd0, 1'b0, 1'b1));
    end
    for (int i = 0; i < 20; i++) begin
      opcode = 6'(i * 5);
      funct = 6'(i * 3);
      zero = i[0];
      tick();
      total++;
      if (snap() !== ex(3'd5, 8'b0, 5'd0, 1'b0, 1'b1)) begin
        bad++;
        $display("FAIL halt_hold cyc%0d got=%h exp=%h", i, snap(), ex(3'd5, 8'b0, 5'd0, 1'b0, 1'b1));
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    run(6'h23, 6'h00, 3);
    total++;
    if (trace[2][17:15] !== 3'd3) begin bad++; $display("FAIL mid_reach_mem state=%0d exp=3", trace[2][17:15]); end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (snap() !== ex(3'd0, 8'b0, 5'd0, 1'b0, 1'b0)) begin
      bad++;
      $display("FAIL mid_reset_async got=%h exp=%h", snap(), ex(3'd0, 8'b0, 5'd0, 1'b0, 1'b0));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (RW !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL mid_reset_hold RW=%b state=%0d exp RW=0 state=0", RW, state); end
    end
    opcode = 6'h04;
    reset = 1'b1;
    tick();
    total++;
    if (RW !== 1'b0 || MW !== 1'b0 || state !== 3'd1) begin
      bad++;
      $display("FAIL mid_reset_after RW=%b MW=%b state=%0d exp 0 0 1", RW, MW, state);
    end
    tick();
    tick();
  endtask

  task automatic test_count;
    logic [5:0] ops [0:9];
    logic [5:0] fns [0:9];
    int ns [0:9];
    logic [31:0] expc;
`ifdef CTRL_INSTR_COUNT_EN
    expc = 32'd10;
`else
    expc = 32'd0;
`endif
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00, 6'h08, 6'h11, 6'h00, 6'h00};
    fns = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h25, 6'h00};
    ns = '{4, 5, 4, 3, 3, 3, 4, 3, 4, 4};
    do_reset();
    total++;
    if (instr_count !== 32'd0) begin bad++; $display("FAIL count_reset got=%0d exp=0", instr_count); end
    for (int k = 0; k < 10; k++) run(ops[k], fns[k], ns[k]);
    total++;
    if (instr_count !== expc) begin bad++; $display("FAIL count_ten got=%0d exp=%0d", instr_count, expc); end
    run(6'h3F, 6'h00, 2);
    repeat (5) tick();
    total++;
    if (instr_count !== expc || halt !== 1'b1) begin
      bad++;
      $display("FAIL count_halted got=%0d halt=%b exp=%0d halt=1", instr_count, halt, expc);
    end
  endtask

  initial begin
    reset = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    test_reset();
    test_rtype();
    test_mem();
    test_branch_jump();
    test_illegal();
    test_halt();
    test_reset_mid();
    test_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
